exec_stage: RTL and testbench

//  Execute stage plus EX/MEM pipeline register; directly downstream of the decode stage.

---
 rtl/exec_stage.sv | 155 +++++++++++++++
 tb/tb_exec_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_stage.sv
// Execute stage with the EX/MEM pipeline register. It performs the ALU operation, selects the
// destination register, adds the branch target, and registers the results for the memory stage.
module exec_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_valid,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic [1:0]            iSig_WB,
  input  logic [2:0]            iSig_MEM,
  input  logic [3:0]            iSig_EX,
  input  logic [DATA_W-1:0]     i_temp_npc,
  input  logic [DATA_W-1:0]     iRegFileRead1,
  input  logic [DATA_W-1:0]     iRegFileRead2,
  input  logic [DATA_W-1:0]     iSignExtended,
  input  logic [REG_ADDR_W-1:0] iins2016,
  input  logic [REG_ADDR_W-1:0] iins1511,
  output logic                  o_valid,
  output logic [1:0]            oSig_WB,
  output logic [2:0]            oSig_MEM,
  output logic [DATA_W-1:0]     o_branch_target,
  output logic                  o_zero,
  output logic [DATA_W-1:0]     o_alu_result,
  output logic [DATA_W-1:0]     o_store_data,
  output logic [REG_ADDR_W-1:0] o_write_reg,
  output logic                  o_illegal
);

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Returns {illegal, result}; unsupported encodings give a zero result.
  function automatic logic [DATA_W:0] aluEval(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic [1:0]               op,
    input logic [5:0]               funct
  );
    logic [DATA_W-1:0] res;
    logic              ill;
    res = '0;
    ill = 1'b0;
    case (op)
      ALUOP_ADD: res = a + b;
      ALUOP_SUB: res = a - b;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  res = a + b;
          FN_SUB:  res = a - b;
          FN_AND:  res = a & b;
          FN_OR:   res = a | b;
          FN_NOR:  res = ~(a | b);
          FN_SLT:  res = (a < b) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    return {ill, res};
  endfunction

  // Stage p0: combinational execute on the decode bundle
  logic signed [DATA_W-1:0]   opA_p0;
  logic signed [DATA_W-1:0]   opB_p0;
  logic [DATA_W-1:0]          aluResult_p0;
  logic                       illegal_p0;
  logic                       zero_p0;
  logic [DATA_W-1:0]          branchTarget_p0;
  logic [REG_ADDR_W-1:0]      writeReg_p0;
  logic                       regDst_p0;
  logic                       aluSrc_p0;
  logic [1:0]                 aluOp_p0;

  always_comb begin
    regDst_p0 = iSig_EX[0];
    aluSrc_p0 = iSig_EX[1];
    aluOp_p0  = iSig_EX[3:2];
    opA_p0    = iRegFileRead1;
    opB_p0    = aluSrc_p0 ? iSignExtended : iRegFileRead2;
    {illegal_p0, aluResult_p0} = aluEval(opA_p0, opB_p0, aluOp_p0, iSignExtended[5:0]);
    zero_p0         = (aluResult_p0 == '0);
    branchTarget_p0 = i_temp_npc + (iSignExtended << 2);
    writeReg_p0     = regDst_p0 ? iins1511 : iins2016;
  end

  // Stage p1: EX/MEM register
  logic                  vld_p1;
  logic [1:0]            sigWb_p1;
  logic [2:0]            sigMem_p1;
  logic                  illegal_p1;
  logic [DATA_W-1:0]     branchTarget_p1;
  logic                  zero_p1;
  logic [DATA_W-1:0]     aluResult_p1;
  logic [DATA_W-1:0]     storeData_p1;
  logic [REG_ADDR_W-1:0] writeReg_p1;

  // Control fields: flush beats stall, and a non-valid capture is a bubble.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1     <= 1'b0;
      sigWb_p1   <= '0;
      sigMem_p1  <= '0;
      illegal_p1 <= 1'b0;
    end else if (i_flush || (!i_stall && !i_valid)) begin
      vld_p1     <= 1'b0;
      sigWb_p1   <= '0;
      sigMem_p1  <= '0;
      illegal_p1 <= 1'b0;
    end else if (!i_stall) begin
      vld_p1     <= 1'b1;
      sigWb_p1   <= illegal_p0 ? 2'b00  : iSig_WB;
      sigMem_p1  <= illegal_p0 ? 3'b000 : iSig_MEM;
      illegal_p1 <= illegal_p0;
    end
  end

  // Datapath fields keep their contents across bubbles; only a valid capture loads them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      branchTarget_p1 <= '0;
      zero_p1         <= 1'b0;
      aluResult_p1    <= '0;
      storeData_p1    <= '0;
      writeReg_p1     <= '0;
    end else if (!i_flush && !i_stall && i_valid) begin
      branchTarget_p1 <= branchTarget_p0;
      zero_p1         <= zero_p0;
      aluResult_p1    <= aluResult_p0;
      storeData_p1    <= iRegFileRead2;
      writeReg_p1     <= writeReg_p0;
    end
  end

  assign o_valid         = vld_p1;
  assign oSig_WB         = sigWb_p1;
  assign oSig_MEM        = sigMem_p1;
  assign o_illegal       = illegal_p1;
  assign o_branch_target = branchTarget_p1;
  assign o_zero          = zero_p1;
  assign o_alu_result    = aluResult_p1;
  assign o_store_data    = storeData_p1;
  assign o_write_reg     = writeReg_p1;

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed scenarios plus randomized traffic compared
// against a behavioural model of the EX/MEM entry.
module tb_exec_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_valid, i_stall, i_flush;
  logic [1:0]    iSig_WB;
  logic [2:0]    iSig_MEM;
  logic [3:0]    iSig_EX;
  logic [DW-1:0] i_temp_npc, iRegFileRead1, iRegFileRead2, iSignExtended;
  logic [AW-1:0] iins2016, iins1511;
  logic          o_valid, o_zero, o_illegal;
  logic [1:0]    oSig_WB;
  logic [2:0]    oSig_MEM;
  logic [DW-1:0] o_branch_target, o_alu_result, o_store_data;
  logic [AW-1:0] o_write_reg;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          valid;
    logic [1:0]    wb;
    logic [2:0]    mem;
    logic [DW-1:0] bt;
    logic          zero;
    logic [DW-1:0] res;
    logic [DW-1:0] sd;
    logic [AW-1:0] wr;
    logic          ill;
  } entry_t;

  entry_t exp;
  entry_t got;

  assign got = '{valid: o_valid, wb: oSig_WB, mem: oSig_MEM, bt: o_branch_target,
                 zero: o_zero, res: o_alu_result, sd: o_store_data, wr: o_write_reg,
                 ill: o_illegal};

  always #5 clk = ~clk;

  exec_stage #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush),
    .iSig_WB(iSig_WB), .iSig_MEM(iSig_MEM), .iSig_EX(iSig_EX), .i_temp_npc(i_temp_npc),
    .iRegFileRead1(iRegFileRead1), .iRegFileRead2(iRegFileRead2),
    .iSignExtended(iSignExtended), .iins2016(iins2016), .iins1511(iins1511),
    .o_valid(o_valid), .oSig_WB(oSig_WB), .oSig_MEM(oSig_MEM),
    .o_branch_target(o_branch_target), .o_zero(o_zero), .o_alu_result(o_alu_result),
    .o_store_data(o_store_data), .o_write_reg(o_write_reg), .o_illegal(o_illegal)
  );

  // Next EX/MEM entry from the current inputs and the previous entry.
  function automatic entry_t modelStep(entry_t prev);
    entry_t n;
    longint unsigned a, b, r;
    bit ill;
    n = prev;
    a = iRegFileRead1;
    b = iSig_EX[1] ? iSignExtended : iRegFileRead2;
    r = 0;
    ill = 0;
    case (iSig_EX[3:2])
      2'd0: r = (a + b) % (64'd1 << DW);
      2'd1: r = (a + (64'd1 << DW) - b) % (64'd1 << DW);
      2'd2: begin
        case (iSignExtended[5:0])
          6'h20: r = (a + b) % (64'd1 << DW);
          6'h22: r = (a + (64'd1 << DW) - b) % (64'd1 << DW);
          6'h24: r = a & b;
          6'h25: r = a | b;
          6'h27: r = (~(a | b)) & ((64'd1 << DW) - 1);
          6'h2A: r = (int'(iRegFileRead1) < int'(b[DW-1:0])) ? 1 : 0;
          default: ill = 1;
        endcase
      end
      default: ill = 1;
    endcase
    if (i_flush || (!i_stall && !i_valid)) begin
      n.valid = 0; n.wb = 0; n.mem = 0; n.ill = 0;
    end else if (!i_stall) begin
      n.valid = 1;
      n.wb    = ill ? 2'b00 : iSig_WB;
      n.mem   = ill ? 3'b000 : iSig_MEM;
      n.ill   = ill;
      n.res   = r[DW-1:0];
      n.zero  = (r == 0);
      n.bt    = DW'((longint'(i_temp_npc) + longint'(iSignExtended) * 4) % (64'd1 << DW));
      n.sd    = iRegFileRead2;
      n.wr    = iSig_EX[0] ? iins1511 : iins2016;
    end
    return n;
  endfunction

  task automatic tick();
    exp = modelStep(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    i_valid = 0; i_stall = 0; i_flush = 0;
    iSig_WB = 0; iSig_MEM = 0; iSig_EX = 0;
    i_temp_npc = 0; iRegFileRead1 = 0; iRegFileRead2 = 0; iSignExtended = 0;
    iins2016 = 0; iins1511 = 0;
  endtask

  task automatic randomInputs();
    logic [5:0] fns [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h3F, 6'h00};
    iSig_WB       = 2'($urandom);
    iSig_MEM      = 3'($urandom);
    iSig_EX       = 4'($urandom);
    i_temp_npc    = $urandom;
    iRegFileRead1 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
    iRegFileRead2 = ($urandom_range(0, 3) == 0) ? iRegFileRead1 : $urandom;
    iSignExtended = $urandom;
    if ($urandom_range(0, 1) == 1)
      iSignExtended = {iSignExtended[31:6], fns[$urandom_range(0, 7)]};
    iins2016      = 5'($urandom);
    iins1511      = 5'($urandom);
  endtask

  task automatic test_reset();
    setIdle();
    rstn = 0;
    exp  = '0;
    #12;
    rstn = 1;
    @(posedge clk); #1;
    // load a live entry, then assert reset mid-stall between edges
    i_valid = 1; iSig_WB = 2'b11; iSig_MEM = 3'b010; iSig_EX = 4'b0010;
    iRegFileRead1 = 32'h10; iSignExtended = 32'h4; iins2016 = 5'd9;
    tick();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_preload got=%h exp=%h", got, exp);
    end
    i_stall = 1;
    #2;
    rstn = 0;
    #1;
    exp = '0;
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_async got=%h exp=0", got);
    end
    @(posedge clk); #1;
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_held got=%h exp=0", got);
    end
    #2;
    rstn = 1;
    i_stall = 0;
    iRegFileRead1 = 32'h21; iSignExtended = 32'h3;
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_alu_result !== 32'h24 || oSig_WB !== 2'b11) begin
      errors++;
      $display("FAIL reset_first_load valid=%b res=%h wb=%b exp 1/00000024/11",
               o_valid, o_alu_result, oSig_WB);
    end
  endtask

  task automatic test_r_add();
    setIdle();
    i_valid = 1; iSig_EX = 4'b1001; iRegFileRead1 = 5; iRegFileRead2 = 7;
    iSignExtended = 32'h20; iins1511 = 3; iins2016 = 8; iSig_WB = 2'b01;
    tick();
    checks++;
    if (o_alu_result !== 32'd12 || o_write_reg !== 5'd3 || o_zero !== 1'b0 ||
        o_valid !== 1'b1 || o_illegal !== 1'b0) begin
      errors++;
      $display("FAIL r_add res=%0d wr=%0d zero=%b valid=%b ill=%b exp 12/3/0/1/0",
               o_alu_result, o_write_reg, o_zero, o_valid, o_illegal);
    end
  endtask

  task automatic test_beq();
    setIdle();
    i_valid = 1; iSig_EX = 4'b0100; iSig_MEM = 3'b001;
    iRegFileRead1 = 32'h1234; iRegFileRead2 = 32'h1234;
    i_temp_npc = 32'h100; iSignExtended = 32'hFFFF_FFFF;
    tick();
    checks++;
    if (o_zero !== 1'b1 || o_branch_target !== 32'hFC || oSig_MEM[0] !== 1'b1 ||
        o_store_data !== 32'h1234) begin
      errors++;
      $display("FAIL beq zero=%b bt=%h mem=%b sd=%h exp 1/000000fc/xx1/00001234",
               o_zero, o_branch_target, oSig_MEM, o_store_data);
    end
  endtask

  task automatic test_slt_wrap();
    setIdle();
    i_valid = 1; iSig_EX = 4'b1001; iRegFileRead1 = 32'hFFFF_FFFF; iRegFileRead2 = 1;
    iSignExtended = 32'h2A;
    tick();
    checks++;
    if (o_alu_result !== 32'd1 || o_zero !== 1'b0) begin
      errors++;
      $display("FAIL slt_signed res=%h zero=%b exp 00000001/0", o_alu_result, o_zero);
    end
    iSignExtended = 32'h20;
    tick();
    checks++;
    if (o_alu_result !== 32'd0 || o_zero !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap res=%h zero=%b exp 00000000/1", o_alu_result, o_zero);
    end
  endtask

  task automatic test_stall_flush();
    entry_t held;
    setIdle();
    i_valid = 1; iSig_WB = 2'b10; iSig_MEM = 3'b100; iSig_EX = 4'b0010;
    iRegFileRead1 = 32'h40; iSignExtended = 32'h8;
    tick();
    held = exp;
    for (int i = 0; i < 3; i++) begin
      i_stall = 1;
      randomInputs();
      i_valid = 1;
      tick();
      checks++;
      if (got !== held) begin
        errors++;
        $display("FAIL stall_hold%0d got=%h exp=%h", i, got, held);
      end
    end
    i_flush = 1;
    tick();
    checks++;
    if (o_valid !== 1'b0 || oSig_WB !== 2'b00 || oSig_MEM !== 3'b000 || o_illegal !== 1'b0) begin
      errors++;
      $display("FAIL stall_flush valid=%b wb=%b mem=%b ill=%b exp 0/00/000/0",
               o_valid, oSig_WB, oSig_MEM, o_illegal);
    end
    i_flush = 0; i_stall = 0; i_valid = 0;
    tick();
    checks++;
    if (o_valid !== 1'b0 || oSig_WB !== 2'b00) begin
      errors++;
      $display("FAIL invalid_bubble valid=%b wb=%b exp 0/00", o_valid, oSig_WB);
    end
  endtask

  task automatic test_illegal();
    setIdle();
    i_valid = 1; iSig_EX = 4'b1000; iSignExtended = 32'h3F;
    iSig_WB = 2'b11; iSig_MEM = 3'b111; iRegFileRead1 = 32'h55; iRegFileRead2 = 32'h66;
    tick();
    checks++;
    if (o_illegal !== 1'b1 || o_alu_result !== 32'd0 || oSig_WB !== 2'b00 ||
        oSig_MEM !== 3'b000 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL illegal_funct ill=%b res=%h wb=%b mem=%b valid=%b exp 1/0/00/000/1",
               o_illegal, o_alu_result, oSig_WB, oSig_MEM, o_valid);
    end
    iSig_EX = 4'b1100; iSignExtended = 32'h20;
    tick();
    checks++;
    if (o_illegal !== 1'b1 || o_alu_result !== 32'd0 || oSig_WB !== 2'b00) begin
      errors++;
      $display("FAIL illegal_aluop ill=%b res=%h wb=%b exp 1/0/00",
               o_illegal, o_alu_result, oSig_WB);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      randomInputs();
      i_valid = ($urandom_range(0, 7) != 0);
      i_stall = ($urandom_range(0, 5) == 0);
      i_flush = ($urandom_range(0, 9) == 0);
      tick();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_r_add();
    test_beq();
    test_slt_wrap();
    test_stall_flush();
    test_illegal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
